// File: rtl/noc_router_pkg.sv
// Shared router constants and the output-arbiter state type.
package noc_router_pkg;

    localparam int NOC_FLIT_WIDTH = 32;
    localparam int NOC_PORTS      = 5;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_arb_rr.sv
// Combinational round-robin picker: one-hot grant from req starting at the
// one-hot prio pointer, plus the pointer that follows the winner.
module noc_arb_rr #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio,
    output logic [N-1:0] gnt,
    output logic [N-1:0] nxt_prio
);

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_prio_dbl;
    logic [2*N-1:0] w_gnt_dbl;
    logic [N-1:0]   w_gnt_rot;

    // Subtracting prio from the doubled request vector clears everything
    // below the pointer, so the lowest surviving bit is the wrapped winner.
    assign w_req_dbl  = {req, req};
    assign w_prio_dbl = {{N{1'b0}}, prio};
    assign w_gnt_dbl  = w_req_dbl & ~(w_req_dbl - w_prio_dbl);
    assign gnt        = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

    always_comb begin
        w_gnt_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt_rot[(i + 1) % N] = gnt[i];
        end
    end

    assign nxt_prio = (|gnt) ? w_gnt_rot : prio;

endmodule

// File: rtl/noc_router_output_arbiter.sv
// Wormhole output-port arbiter: round-robin pick of a head flit, then the
// grant is held until that packet's last flit has been accepted.
module noc_router_output_arbiter
    import noc_router_pkg::*;
#(
    parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
    parameter int INPUTS     = NOC_PORTS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    arb_state_t              r_state;
    logic [INPUTS-1:0]       r_grant;
    logic [INPUTS-1:0]       r_prio;

    logic [INPUTS-1:0]       w_sel;
    logic [INPUTS-1:0]       w_sel_nxt_prio;
    logic [INPUTS-1:0]       w_grant_rot;
    logic [INPUTS-1:0]       w_pick;
    logic [FLIT_WIDTH-1:0]   w_mux_flit;
    logic                    w_mux_last;
    logic                    w_valid;
    logic                    w_xfer;

    noc_arb_rr #(
        .N(INPUTS)
    ) u_rr (
        .req      (in_valid),
        .prio     (r_prio),
        .gnt      (w_sel),
        .nxt_prio (w_sel_nxt_prio)
    );

    always_comb begin
        w_grant_rot = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_grant_rot[(i + 1) % INPUTS] = r_grant[i];
        end
    end

    assign w_pick = (r_state == ARB_LOCKED) ? r_grant : w_sel;

    always_comb begin
        w_mux_flit = '0;
        w_mux_last = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (w_pick[i]) begin
                w_mux_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                w_mux_last = in_last[i];
            end
        end
    end

    // Outputs are gated by rst_n so the link is quiet for the whole reset.
    assign w_valid   = |(w_pick & in_valid);
    assign out_valid = rst_n & w_valid;
    assign out_flit  = rst_n ? w_mux_flit : '0;
    assign out_last  = rst_n & w_mux_last;
    assign in_ready  = (rst_n && out_ready) ? w_pick : '0;
    assign w_xfer    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_prio  <= INPUTS'(1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_xfer) begin
                        if (w_mux_last) begin
                            r_prio <= w_sel_nxt_prio;
                        end else begin
                            r_state <= ARB_LOCKED;
                            r_grant <= w_sel;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (w_xfer && w_mux_last) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                        r_prio  <= w_grant_rot;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_router_output_arbiter.sv
// Bench for noc_router_output_arbiter: directed scenarios plus random worms,
// all checked cycle by cycle against an index-based arbitration model.
module tb_noc_router_output_arbiter;

    localparam int N  = 5;
    localparam int FW = 32;

    logic              clk;
    logic              rst_n;
    logic [N*FW-1:0]   in_flit;
    logic [N-1:0]      in_last;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    int n_checks;
    int n_fails;

    // model state: lock flag, owning input, index of highest-priority input
    bit m_locked;
    int m_owner;
    int m_prio;

    noc_router_output_arbiter #(
        .FLIT_WIDTH (FW),
        .INPUTS     (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int i, input bit v, input bit l, input logic [FW-1:0] f);
        in_valid[i] = v;
        in_last[i]  = l;
        in_flit[i*FW +: FW] = f;
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_last  = '0;
        in_flit  = '0;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_prio   = 0;
    endtask

    // Called just after a negedge with inputs settled; checks, clocks, updates model.
    task automatic step(output bit xf, output logic [N-1:0] ro, output bit ov);
        logic [N-1:0] e_rdy;
        bit           e_ov;
        int           s;
        int           c;
        s     = -1;
        e_ov  = 1'b0;
        e_rdy = '0;
        if (rst_n) begin
            if (m_locked) begin
                s    = m_owner;
                e_ov = in_valid[s];
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (m_prio + k) % N;
                    if (s < 0 && in_valid[c]) s = c;
                end
                e_ov = (s >= 0);
            end
            if (s >= 0) e_rdy[s] = out_ready;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
        if (e_ov) begin
            chk("out_flit", 64'(out_flit), 64'(in_flit[s*FW +: FW]));
            chk("out_last", 64'(out_last), 64'(in_last[s]));
        end
        if (!rst_n) begin
            chk("rst_out_flit", 64'(out_flit), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
        end
        ro = in_ready;
        ov = out_valid;
        xf = e_ov && out_ready && rst_n;
        @(posedge clk);
        if (xf) begin
            if (in_last[s]) begin
                m_locked = 1'b0;
                m_prio   = (s + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = s;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit            xf;
        bit            ov;
        logic [N-1:0]  ro;
        logic [N-1:0]  exp_r;
        int            rem2;
        int            rem1;
        int            rem[N];
        bit            pat[6];

        n_checks = 0;
        n_fails  = 0;
        model_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_in();

        // reset held with every input requesting
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b1, 32'hA000_0000 | 32'(i));
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            step(xf, ro, ov);
            chk("rst_in_ready", 64'(ro), 64'd0);
            chk("rst_out_valid", 64'(ov), 64'd0);
        end
        rst_n = 1'b1;

        // fairness: single-flit packets from all inputs, served 0..4
        for (int k = 0; k < N; k++) begin
            step(xf, ro, ov);
            exp_r = '0;
            exp_r[k] = 1'b1;
            chk("rr_order", 64'(ro), 64'(exp_r));
            in_valid[k] = 1'b0;
        end
        for (int i = 0; i < N; i++) in_valid[i] = 1'b1;
        out_ready = 1'b0;
        step(xf, ro, ov);
        chk("rr_back_to_0_ov", 64'(ov), 64'd1);
        chk("rr_back_to_0_flit", 64'(out_flit), 64'hA000_0000);

        // 4-flit worm on input 2 with input 3 waiting, ready toggling
        clear_in();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rem2 = 4;
        for (int c = 0; c < 6; c++) begin
            set_in(2, rem2 > 0, rem2 == 1, 32'h2000_0000 | 32'(rem2));
            set_in(3, 1'b1, 1'b1, 32'h3333_0003);
            out_ready = pat[c];
            step(xf, ro, ov);
            chk("worm_in3_blocked", 64'(ro[3]), 64'd0);
            if (xf) rem2--;
        end
        chk("worm_all_flits", 64'(rem2), 64'd0);
        in_valid[2] = 1'b0;
        out_ready   = 1'b1;
        step(xf, ro, ov);
        chk("in3_after_worm", 64'(ro), 64'b01000);

        // mid-worm bubble on input 1 while input 4 waits
        clear_in();
        rem1 = 3;
        for (int c = 0; c < 5; c++) begin
            set_in(1, (c == 0 || c >= 3), rem1 == 1, 32'h1000_0000 | 32'(rem1));
            set_in(4, c >= 1, 1'b1, 32'h4444_0004);
            step(xf, ro, ov);
            chk("bubble_in4_blocked", 64'(ro[4]), 64'd0);
            if (c == 1 || c == 2) chk("bubble_out_valid", 64'(ov), 64'd0);
            if (xf) rem1--;
        end
        chk("bubble_all_flits", 64'(rem1), 64'd0);
        in_valid[1] = 1'b0;
        step(xf, ro, ov);
        chk("in4_after_bubble", 64'(ro), 64'b10000);

        // wrap-around: move pointer to 4, then requests on 0 and 4
        clear_in();
        set_in(3, 1'b1, 1'b1, 32'h3333_1111);
        step(xf, ro, ov);
        clear_in();
        set_in(0, 1'b1, 1'b1, 32'h0000_AAAA);
        set_in(4, 1'b1, 1'b1, 32'h4444_BBBB);
        step(xf, ro, ov);
        chk("wrap_first_4", 64'(ro), 64'b10000);
        in_valid[4] = 1'b0;
        step(xf, ro, ov);
        chk("wrap_then_0", 64'(ro), 64'b00001);

        // reset during input 3's 5-flit worm
        clear_in();
        for (int c = 0; c < 2; c++) begin
            set_in(3, 1'b1, 1'b0, 32'h3000_0000 | 32'(c));
            step(xf, ro, ov);
        end
        rst_n = 1'b0;
        model_reset();
        step(xf, ro, ov);
        chk("midworm_rst_ready", 64'(ro), 64'd0);
        rst_n = 1'b1;
        set_in(1, 1'b1, 1'b1, 32'h1111_0001);
        step(xf, ro, ov);
        chk("after_rst_in1", 64'(ro), 64'b00010);

        // random multi-flit traffic with bubbles and backpressure
        clear_in();
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                rst_n = 1'b0;
                model_reset();
                for (int i = 0; i < N; i++) rem[i] = 0;
                clear_in();
                step(xf, ro, ov);
                rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && ($urandom % 3) == 0) rem[i] = 1 + int'($urandom % 4);
                set_in(i, (rem[i] > 0) && (($urandom % 4) != 0), rem[i] == 1, FW'($urandom));
            end
            out_ready = (($urandom % 10) < 7);
            step(xf, ro, ov);
            if (xf) begin
                for (int i = 0; i < N; i++) if (ro[i]) rem[i]--;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/noc_router_output_arbiter.md
Name: noc_router_output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router.
- Shares one output link between INPUTS requesters using round-robin arbitration. Requesters are the per-input route lookup stages, each presenting a valid bit for this output.
- Once a head flit is granted, the grant is locked until the last flit of that packet is accepted.
- Sits between the lookup stages and the output buffer/link of one router port.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- INPUTS, 5, number of requesting input ports (≥1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_flit  input  INPUTS*FLIT_WIDTH  flit of input i at [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_last  input  INPUTS  last-flit marker per input.
- in_valid  input  INPUTS  request/valid per input.
- in_ready  output  INPUTS  ready per input.
- out_flit  output  FLIT_WIDTH  selected flit.
- out_last  output  1  selected last marker.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- State register: state ∈ {IDLE, LOCKED}, grant[INPUTS] (one-hot), prio[INPUTS] (one-hot round-robin pointer).
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, prio=1 (input 0 highest). While in reset: out_valid=0 and in_ready=0 (forced), out_flit=0, out_last=0.
- Datapath is combinational: zero cycles latency from in_* to out_*. The flit transfers when out_valid & out_ready.
- IDLE:
  - sel = round-robin pick of in_valid starting at prio, wrapping at INPUTS-1 → 0.
  - out_valid = |in_valid. out_flit/out_last come from sel.
  - in_ready = sel & {INPUTS{out_ready}}.
  - On transfer with !last: state→LOCKED, grant←sel.
  - On transfer with last (single-flit packet): stay IDLE, prio←rotate-left(sel) by 1 with wrap.
  - No transfer: no state change. The sel choice is not sticky, so a lower-priority requester arriving later may win if the higher one drops valid.
- LOCKED:
  - out_valid = |(grant & in_valid). Mux selects grant.
  - in_ready = grant & {INPUTS{out_ready}}. Other inputs see in_ready=0 regardless of their valid.
  - On transfer with last: state→IDLE, grant←0, prio←rotate-left(grant) by 1.
  - The granted input dropping valid mid-worm (bubble) holds the lock; out_valid=0 that cycle.
- in_ready is one-hot or zero at all times. out_* never mixes bits from two inputs.
- out_flit/out_last are don't-care when out_valid=0. The RTL drives the mux of sel/grant; when nothing is selected it drives 0.
- Round-robin fairness: with all inputs continuously requesting single-flit packets, the grant sequence is 0,1,…,INPUTS-1,0,…
- INPUTS=1: pointer logic degenerates; the block behaves as a pass-through with a lock.
- Reset asserted mid-worm: lock dropped immediately. After release, arbitration restarts from input 0. The partial worm is lost; upstream is reset by the same rst_n.

Decomposition:
- Sub-module noc_arb_rr (combinational): inputs req[N] and prio[N] one-hot; outputs gnt[N] one-hot and nxt_prio[N]. Implemented with double-width request masking to handle wrap-around. Reusable by other router arbiters.
- The arbiter state enum (IDLE/LOCKED) lives in the shared package noc_router_pkg, alongside the existing router constants. No other typedefs are needed.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 → out_valid=0 and in_ready=0. After release, input 0 is granted first.
- INPUTS=5, all inputs send one single-flit packet each (in_last=1), out_ready=1 → exactly one transfer per cycle, in order 0,1,2,3,4. Then prio=input 0.
- Input 2 sends a 4-flit worm while input 3 requests; out_ready toggles 1,0,1,1,0,1 → all 4 flits of input 2 appear contiguously, with in_ready[3]=0 throughout. Input 3 is granted the cycle after input 2's last flit transfers.
- Mid-worm bubble: input 1 worm of 3 flits, in_valid[1]=0 for 2 cycles after flit 1, input 4 valid meanwhile → out_valid=0 during the bubble and input 4 is not granted until input 1's last flit.
- Wrap-around: prio at input 4, requests on inputs 0 and 4 → input 4 granted first, then input 0.
- Reset mid-worm: assert rst_n=0 after flit 2 of input 3's 5-flit worm → grant cleared asynchronously. After release, a request from input 1 is granted immediately.
